por_seq_ctl: RTL

Parametrised power-on-reset sequencer, successor to the fixed-width POR digital controller in the sky130 POR macro. It synchronises the analog `pwup_filt` comparator output, then runs a startup one-shot and a POR one-shot, each with a parameterised width. It then releases `N_CH` active-low reset channels in a staggered order, and it restarts the whole sequence on any brownout. It also supplies the trip-voltage decoder and the oscillator-enable logic to the analog front end.

---
 rtl/por_seq_ctl_if.sv | 41 ++++
 rtl/por_seq_ctl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/por_seq_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module   : por_seq_ctl_if
//  Brief    : Analog front-end / reset-channel bundle of the POR sequencer.
//  Revision : 1.0 - initial release
// ============================================================================

interface por_seq_ctl_if #(
    parameter int TRIP_W = 3,
    parameter int N_CH   = 2
);
    logic                      pwup_filt;
    logic [TRIP_W-1:0]         otrip;
    logic                      force_pdn;
    logic                      force_rc_osc;
    logic                      force_short_oneshot;
    logic                      osc_ena;
    logic [(2**TRIP_W)-1:0]    otrip_decoded;
    logic                      force_pdnb;
    logic                      por_unbuf;
    logic [N_CH-1:0]           rstn_ch;
    logic                      startup_timed_out;
    logic                      por_timed_out;
    logic [2:0]                seq_state;
    logic [3:0]                brownout_cnt;

    // master = analog front end / system side, slave = sequencer
    modport master (
        output pwup_filt, otrip, force_pdn, force_rc_osc, force_short_oneshot,
        input  osc_ena, otrip_decoded, force_pdnb, por_unbuf, rstn_ch,
               startup_timed_out, por_timed_out, seq_state, brownout_cnt
    );

    modport slave (
        input  pwup_filt, otrip, force_pdn, force_rc_osc, force_short_oneshot,
        output osc_ena, otrip_decoded, force_pdnb, por_unbuf, rstn_ch,
               startup_timed_out, por_timed_out, seq_state, brownout_cnt
    );
endinterface

`default_nettype wire

// File: rtl/por_seq_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : por_seq_ctl
//  Brief    : Power-on-reset sequencer: startup/POR one-shots, staggered
//             release of active-low reset channels, brownout restart.
//  Revision : 1.0 - initial release
// ============================================================================

module por_seq_ctl #(
    parameter int TRIP_W   = 3,
    parameter int ST_W     = 5,
    parameter int POR_W    = 11,
    parameter int N_CH     = 2,
    parameter int STAG_W   = 4,
    parameter int SYNC_STG = 3
) (
    input  wire logic     osc_ck,
    input  wire logic     rst,
    por_seq_ctl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STARTUP = 3'd1,
        S_POR     = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int              c_ch_w     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [ST_W:0]   c_st_max   = {1'b0, {ST_W{1'b1}}};
    localparam logic [ST_W:0]   c_st_one   = (ST_W+1)'(1);
    localparam logic [ST_W:0]   c_st_step  = (ST_W+1)'(2**(ST_W-4));
    localparam logic [POR_W:0]  c_por_max  = {1'b0, {POR_W{1'b1}}};
    localparam logic [POR_W:0]  c_por_one  = (POR_W+1)'(1);
    localparam logic [POR_W:0]  c_por_step = (POR_W+1)'(2**(POR_W-4));

    logic [SYNC_STG-1:0] r_sync;
    logic                w_pwup_s;
    logic                w_down;

    state_t              r_state,   w_state_nxt;
    logic [ST_W-1:0]     r_cnt_st,  w_cnt_st_nxt;
    logic [POR_W-1:0]    r_cnt_por, w_cnt_por_nxt;
    logic [STAG_W-1:0]   r_stag,    w_stag_nxt;
    logic [c_ch_w-1:0]   r_ch_idx,  w_ch_idx_nxt;
    logic [N_CH-1:0]     r_rstn_ch, w_rstn_ch_nxt;
    logic [3:0]          r_brown,   w_brown_nxt;
    logic                r_por_unbuf;
    logic                r_st_to;
    logic                r_por_to;

    logic [ST_W:0]       w_st_sum;
    logic [ST_W-1:0]     w_st_adv;
    logic [POR_W:0]      w_por_sum;
    logic [POR_W-1:0]    w_por_adv;
    int                  w_rel_idx;

    assign w_pwup_s = r_sync[SYNC_STG-1];
    assign w_down   = ~w_pwup_s | bus.force_pdn;

    // Short mode jumps by 2**(W-4) and clamps at all-ones, giving 17 counts
    assign w_st_sum  = {1'b0, r_cnt_st} + (bus.force_short_oneshot ? c_st_step : c_st_one);
    assign w_st_adv  = (w_st_sum > c_st_max) ? c_st_max[ST_W-1:0] : w_st_sum[ST_W-1:0];
    assign w_por_sum = {1'b0, r_cnt_por} + (bus.force_short_oneshot ? c_por_step : c_por_one);
    assign w_por_adv = (w_por_sum > c_por_max) ? c_por_max[POR_W-1:0] : w_por_sum[POR_W-1:0];

    assign w_rel_idx = int'(r_ch_idx) + 1;

    always_ff @(posedge osc_ck) begin
        if (rst) begin
            r_sync      <= '0;
            r_state     <= S_IDLE;
            r_cnt_st    <= '0;
            r_cnt_por   <= '0;
            r_stag      <= '0;
            r_ch_idx    <= '0;
            r_rstn_ch   <= '0;
            r_brown     <= 4'd0;
            r_por_unbuf <= 1'b0;
            r_st_to     <= 1'b0;
            r_por_to    <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STG-2:0], bus.pwup_filt};
            r_state     <= w_state_nxt;
            r_cnt_st    <= w_cnt_st_nxt;
            r_cnt_por   <= w_cnt_por_nxt;
            r_stag      <= w_stag_nxt;
            r_ch_idx    <= w_ch_idx_nxt;
            r_rstn_ch   <= w_rstn_ch_nxt;
            r_brown     <= w_brown_nxt;
            r_por_unbuf <= (w_state_nxt == S_POR);
            r_st_to     <= (w_state_nxt inside {S_POR, S_RELEASE, S_DONE});
            r_por_to    <= (w_state_nxt inside {S_RELEASE, S_DONE});
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_st_nxt  = r_cnt_st;
        w_cnt_por_nxt = r_cnt_por;
        w_stag_nxt    = r_stag;
        w_ch_idx_nxt  = r_ch_idx;
        w_rstn_ch_nxt = r_rstn_ch;
        w_brown_nxt   = r_brown;

        // A supply drop overrides any terminal count in the same cycle
        if (w_down) begin
            if (r_state != S_IDLE) begin
                w_state_nxt   = S_IDLE;
                w_cnt_st_nxt  = '0;
                w_cnt_por_nxt = '0;
                w_stag_nxt    = '0;
                w_ch_idx_nxt  = '0;
                w_rstn_ch_nxt = '0;
                if (r_state == S_DONE && r_brown != 4'hF) begin
                    w_brown_nxt = r_brown + 4'd1;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt  = S_STARTUP;
                    w_cnt_st_nxt = '0;
                end
                S_STARTUP: begin
                    if (r_cnt_st == '1) begin
                        w_state_nxt   = S_POR;
                        w_cnt_por_nxt = '0;
                    end else begin
                        w_cnt_st_nxt = w_st_adv;
                    end
                end
                S_POR: begin
                    if (r_cnt_por == '1) begin
                        w_rstn_ch_nxt[0] = 1'b1;
                        if (N_CH == 1) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt  = S_RELEASE;
                            w_stag_nxt   = '0;
                            w_ch_idx_nxt = '0;
                        end
                    end else begin
                        w_cnt_por_nxt = w_por_adv;
                    end
                end
                S_RELEASE: begin
                    w_stag_nxt = r_stag + STAG_W'(1);
                    if (r_stag == '1) begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (k == w_rel_idx) begin
                                w_rstn_ch_nxt[k] = 1'b1;
                            end
                        end
                        if (w_rel_idx == N_CH - 1) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_ch_idx_nxt = r_ch_idx + c_ch_w'(1);
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < 2**TRIP_W; i++) begin : g_trip_dec
        assign bus.otrip_decoded[i] = (bus.otrip == TRIP_W'(i));
    end

    assign bus.force_pdnb        = ~bus.force_pdn;
    assign bus.osc_ena           = bus.force_rc_osc | (w_pwup_s & ~r_por_to);
    assign bus.por_unbuf         = r_por_unbuf;
    assign bus.rstn_ch           = r_rstn_ch;
    assign bus.startup_timed_out = r_st_to;
    assign bus.por_timed_out     = r_por_to;
    assign bus.seq_state         = r_state;
    assign bus.brownout_cnt      = r_brown;

endmodule

`default_nettype wire
